// File: rtl/parking_pkg.sv
// parking_pkg: car park capacity constants, gate timing defaults and gate state encoding
package parking_pkg;
  localparam int MAX_UNI_CAPACITY = 500;
  localparam int MAX_TOTAL_CAPACITY = 700;
  localparam int BASE_FREE_CAPACITY = 200;
  localparam int OPEN_TIMEOUT_DEF = 200;
  localparam int DENY_HOLD_DEF = 16;
  localparam int VAC_SETTLE_DEF = 3;
  localparam int TIMER_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, CHECK, OPEN, REQ, WAIT_CLEAR, DENY} gate_state_t;
endpackage

// File: rtl/parking_gate_channel.sv
// parking_gate_channel: one barrier FSM (arrival, vacancy check, open/timeout, event request, clear-out)
module parking_gate_channel
  import parking_pkg::*;
#(
  parameter bit CHECK_VACANCY = 1'b1,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int DENY_HOLD = DENY_HOLD_DEF,
  parameter int TIMER_W = TIMER_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic car_present,
  input  logic is_uni,
  input  logic car_passed,
  input  logic vac_uni,
  input  logic vac_free,
  input  logic settle_busy,
  input  logic grant,
  output logic gate_open,
  output logic denied,
  output logic req,
  output logic uni,
  output logic timeout,
  output logic deny_pulse
);
  gate_state_t state, nxt;
  logic [TIMER_W-1:0] timer;
  logic vac;
  assign vac = uni ? vac_uni : vac_free;
  assign gate_open = state == OPEN;
  assign denied = state == DENY;
  assign req = state == REQ;
  always_comb begin
    nxt = state;
    timeout = 1'b0;
    deny_pulse = 1'b0;
    case (state)
      IDLE: nxt = car_present ? CHECK : IDLE;
      CHECK:
        if (!CHECK_VACANCY) nxt = OPEN;
        else if (!settle_busy) begin
          nxt = vac ? OPEN : DENY;
          deny_pulse = !vac;
        end
      OPEN:
        if (car_passed) nxt = REQ;
        else if (timer == TIMER_W'(OPEN_TIMEOUT - 1)) begin
          nxt = WAIT_CLEAR;
          timeout = 1'b1;
        end
      REQ: nxt = grant ? WAIT_CLEAR : REQ;
      WAIT_CLEAR: nxt = (car_present || car_passed) ? WAIT_CLEAR : IDLE;
      DENY: nxt = (timer >= TIMER_W'(DENY_HOLD - 1) && !car_present) ? IDLE : DENY;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      uni <= 1'b0;
    end else begin
      state <= nxt;
      timer <= (nxt != state) ? '0 : timer + TIMER_W'(~&timer);
      if (state == IDLE && car_present) uni <= is_uni;
    end
endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: entry/exit barriers, single-event arbiter, vacancy settle and denial count
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int DENY_HOLD = DENY_HOLD_DEF,
  parameter int VAC_SETTLE = VAC_SETTLE_DEF,
  parameter int TIMER_W = TIMER_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_car_present,
  input  logic       entry_is_uni,
  input  logic       entry_car_passed,
  input  logic       exit_car_present,
  input  logic       exit_is_uni,
  input  logic       exit_car_passed,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_denied,
  output logic       gate_timeout,
  output logic [7:0] denied_count
);
  localparam int SW = $clog2(VAC_SETTLE + 1);
  logic en_req, ex_req, en_uni, ex_uni, en_to, ex_to, en_dp, ex_dp, ex_dn;
  logic grant_en, grant_ex, exit_unused;
  logic [SW-1:0] settle;
  assign grant_en = en_req;
  assign grant_ex = ex_req & ~en_req;
  assign exit_unused = ex_dn | ex_dp;
  parking_gate_channel #(
    .CHECK_VACANCY(1'b1), .OPEN_TIMEOUT(OPEN_TIMEOUT), .DENY_HOLD(DENY_HOLD), .TIMER_W(TIMER_W)
  ) u_entry (
    .clk(clk), .reset(reset), .car_present(entry_car_present), .is_uni(entry_is_uni),
    .car_passed(entry_car_passed), .vac_uni(uni_is_vacated_space), .vac_free(is_vacated_space),
    .settle_busy(settle != '0), .grant(grant_en), .gate_open(entry_gate_open),
    .denied(entry_denied), .req(en_req), .uni(en_uni), .timeout(en_to), .deny_pulse(en_dp)
  );
  parking_gate_channel #(
    .CHECK_VACANCY(1'b0), .OPEN_TIMEOUT(OPEN_TIMEOUT), .DENY_HOLD(DENY_HOLD), .TIMER_W(TIMER_W)
  ) u_exit (
    .clk(clk), .reset(reset), .car_present(exit_car_present), .is_uni(exit_is_uni),
    .car_passed(exit_car_passed), .vac_uni(1'b0), .vac_free(1'b0),
    .settle_busy(1'b0), .grant(grant_ex), .gate_open(exit_gate_open),
    .denied(ex_dn), .req(ex_req), .uni(ex_uni), .timeout(ex_to), .deny_pulse(ex_dp)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      car_entered <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited <= 1'b0;
      is_uni_car_exited <= 1'b0;
      gate_timeout <= 1'b0;
      settle <= '0;
      denied_count <= '0;
    end else begin
      car_entered <= grant_en;
      is_uni_car_entered <= grant_en & en_uni;
      car_exited <= grant_ex;
      is_uni_car_exited <= grant_ex & ex_uni;
      gate_timeout <= en_to | ex_to;
      settle <= (car_entered | car_exited) ? SW'(VAC_SETTLE) : settle - SW'(settle != '0);
      denied_count <= denied_count + 8'(en_dp && denied_count != 8'hff);
    end
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed plus randomized scoreboard bench for the gate controller
module tb_parking_gate_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic entry_car_present = 0, entry_is_uni = 0, entry_car_passed = 0;
  logic exit_car_present = 0, exit_is_uni = 0, exit_car_passed = 0;
  logic uni_is_vacated_space = 0, is_vacated_space = 0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_gate_open, exit_gate_open, entry_denied, gate_timeout;
  logic [7:0] denied_count;
  int checks = 0, errors = 0, cyc = 0, exp_denied = 0, last_en = -10, last_ex = -10;
  bit q_en[$], q_ex[$];
  bit eu, xu;
  parking_gate_controller dut (
    .clk(clk), .reset(reset), .entry_car_present(entry_car_present), .entry_is_uni(entry_is_uni),
    .entry_car_passed(entry_car_passed), .exit_car_present(exit_car_present), .exit_is_uni(exit_is_uni),
    .exit_car_passed(exit_car_passed), .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space(is_vacated_space), .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited), .entry_gate_open(entry_gate_open),
    .exit_gate_open(exit_gate_open), .entry_denied(entry_denied), .gate_timeout(gate_timeout),
    .denied_count(denied_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int sat_inc(input int v);
    return v >= 255 ? 255 : v + 1;
  endfunction
  always @(negedge clk)
    if (!reset) begin
      if (car_entered && car_exited) begin
        checks++;
        errors++;
        $display("FAIL both_events: car_entered=1 car_exited=1 in cycle %0d, expected one at a time", cyc);
      end
      if (car_entered) begin
        checks++;
        last_en = cyc;
        if (q_en.size() == 0) begin
          errors++;
          $display("FAIL unexpected_car_entered: pulse in cycle %0d, expected none", cyc);
        end else begin
          eu = q_en.pop_front();
          if (is_uni_car_entered !== eu) begin
            errors++;
            $display("FAIL entry_category: got %0d expected %0d", is_uni_car_entered, eu);
          end
        end
      end else if (is_uni_car_entered) begin
        checks++;
        errors++;
        $display("FAIL entry_flag_idle: is_uni_car_entered=1 expected 0 without event");
      end
      if (car_exited) begin
        checks++;
        last_ex = cyc;
        if (q_ex.size() == 0) begin
          errors++;
          $display("FAIL unexpected_car_exited: pulse in cycle %0d, expected none", cyc);
        end else begin
          xu = q_ex.pop_front();
          if (is_uni_car_exited !== xu) begin
            errors++;
            $display("FAIL exit_category: got %0d expected %0d", is_uni_car_exited, xu);
          end
        end
      end else if (is_uni_car_exited) begin
        checks++;
        errors++;
        $display("FAIL exit_flag_idle: is_uni_car_exited=1 expected 0 without event");
      end
    end
  task automatic entry_txn();
    bit u, v, p;
    int n;
    u = 1'($urandom_range(0, 1));
    v = $urandom_range(0, 3) != 0;
    p = $urandom_range(0, 7) != 0;
    uni_is_vacated_space = u ? v : 1'($urandom_range(0, 1));
    is_vacated_space = u ? 1'($urandom_range(0, 1)) : v;
    entry_is_uni = u;
    entry_car_present = 1;
    n = 0;
    while (!entry_gate_open && !entry_denied && n < 20) begin
      tick();
      n++;
    end
    entry_is_uni = 1'($urandom_range(0, 1));
    chk("entry_decision_made", int'(entry_gate_open | entry_denied), 1);
    chk("entry_vacancy_decision", int'(entry_gate_open), int'(v));
    if (entry_denied) begin
      exp_denied = sat_inc(exp_denied);
      tick($urandom_range(0, 25));
      entry_car_present = 0;
      n = 0;
      while (entry_denied && n < 40) begin
        tick();
        n++;
      end
      chk("entry_deny_release", int'(entry_denied), 0);
    end else if (p) begin
      q_en.push_back(u);
      tick($urandom_range(0, 5));
      entry_car_passed = 1;
      tick($urandom_range(1, 3));
      entry_car_present = 0;
      tick($urandom_range(0, 2));
      entry_car_passed = 0;
    end else begin
      n = 0;
      while (entry_gate_open && n < 250) begin
        n++;
        tick();
      end
      chk("entry_open_duration", n, 200);
      chk("entry_timeout_pulse", int'(gate_timeout), 1);
      tick($urandom_range(0, 3));
      entry_car_present = 0;
    end
    tick($urandom_range(3, 5));
  endtask
  task automatic exit_txn();
    bit u, p;
    int n;
    u = 1'($urandom_range(0, 1));
    p = $urandom_range(0, 7) != 0;
    exit_is_uni = u;
    exit_car_present = 1;
    n = 0;
    while (!exit_gate_open && n < 20) begin
      tick();
      n++;
    end
    exit_is_uni = 1'($urandom_range(0, 1));
    chk("exit_open_latency", n, 2);
    if (p) begin
      q_ex.push_back(u);
      tick($urandom_range(0, 5));
      exit_car_passed = 1;
      tick($urandom_range(1, 3));
      exit_car_present = 0;
      tick($urandom_range(0, 2));
      exit_car_passed = 0;
    end else begin
      n = 0;
      while (exit_gate_open && n < 250) begin
        n++;
        tick();
      end
      chk("exit_open_duration", n, 200);
      chk("exit_timeout_pulse", int'(gate_timeout), 1);
      tick($urandom_range(0, 3));
      exit_car_present = 0;
    end
    tick($urandom_range(3, 5));
  endtask
  initial begin
    int n;
    bit seen_open;
    tick(2);
    chk("reset_outputs", int'({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        entry_gate_open, exit_gate_open, entry_denied, gate_timeout, denied_count}), 0);
    reset = 0;
    tick(2);
    // accepted uni car
    uni_is_vacated_space = 1;
    is_vacated_space = 1;
    entry_is_uni = 1;
    entry_car_present = 1;
    tick();
    chk("uni_gate_not_yet_open", int'(entry_gate_open), 0);
    tick();
    chk("uni_gate_open_2cyc", int'(entry_gate_open), 1);
    q_en.push_back(1);
    entry_car_passed = 1;
    tick();
    chk("uni_gate_closed_on_pass", int'(entry_gate_open), 0);
    tick(10);
    chk("uni_single_event", q_en.size(), 0);
    entry_car_present = 0;
    entry_car_passed = 0;
    tick(3);
    // denied free car
    is_vacated_space = 0;
    entry_is_uni = 0;
    entry_car_present = 1;
    tick(2);
    chk("free_denied", int'(entry_denied), 1);
    n = 1;
    seen_open = 0;
    repeat (5) begin
      tick();
      n += int'(entry_denied);
      seen_open |= entry_gate_open;
    end
    entry_car_present = 0;
    while (entry_denied && n < 100) begin
      tick();
      n += int'(entry_denied);
      seen_open |= entry_gate_open;
    end
    exp_denied = sat_inc(exp_denied);
    chk("deny_hold_min16", int'(n >= 16), 1);
    chk("deny_gate_never_open", int'(seen_open), 0);
    chk("denied_count_one", int'(denied_count), exp_denied);
    tick(2);
    // simultaneous requests
    is_vacated_space = 1;
    entry_is_uni = 0;
    exit_is_uni = 1;
    entry_car_present = 1;
    exit_car_present = 1;
    tick(2);
    chk("both_gates_open", int'({entry_gate_open, exit_gate_open}), 3);
    q_en.push_back(0);
    q_ex.push_back(1);
    entry_car_passed = 1;
    exit_car_passed = 1;
    tick(5);
    chk("exit_follows_entry", last_ex - last_en, 1);
    {entry_car_present, exit_car_present, entry_car_passed, exit_car_passed} = '0;
    tick(4);
    // entry timeout
    entry_is_uni = 1;
    entry_car_present = 1;
    tick(2);
    n = 0;
    while (entry_gate_open && n < 300) begin
      n++;
      tick();
    end
    chk("timeout_open_cycles", n, 200);
    chk("timeout_pulse", int'(gate_timeout), 1);
    tick();
    chk("timeout_pulse_one_cycle", int'(gate_timeout), 0);
    entry_car_present = 0;
    tick(3);
    // settle hold on a back-to-back arrival
    entry_car_present = 1;
    tick(2);
    q_en.push_back(1);
    entry_car_passed = 1;
    tick();
    entry_car_present = 0;
    entry_car_passed = 0;
    tick();
    chk("settle_first_event", int'(car_entered), 1);
    tick();
    entry_car_present = 1;
    tick();
    uni_is_vacated_space = 0;
    chk("settle_hold_1", int'(entry_gate_open | entry_denied), 0);
    tick();
    chk("settle_hold_2", int'(entry_gate_open | entry_denied), 0);
    tick();
    chk("settle_hold_3", int'(entry_gate_open | entry_denied), 0);
    tick();
    exp_denied = sat_inc(exp_denied);
    chk("settle_refreshed_deny", int'(entry_denied), 1);
    chk("settle_denied_count", int'(denied_count), exp_denied);
    entry_car_present = 0;
    n = 0;
    while (entry_denied && n < 40) begin
      tick();
      n++;
    end
    tick(2);
    // reset during OPEN
    uni_is_vacated_space = 1;
    entry_car_present = 1;
    tick(2);
    chk("pre_reset_open", int'(entry_gate_open), 1);
    #2 reset = 1;
    #1;
    exp_denied = 0;
    chk("reset_gate_closed", int'(entry_gate_open), 0);
    chk("reset_denied_count", int'(denied_count), exp_denied);
    tick();
    reset = 0;
    tick();
    chk("post_reset_check", int'(entry_gate_open), 0);
    tick();
    chk("post_reset_open", int'(entry_gate_open), 1);
    q_en.push_back(1);
    entry_car_passed = 1;
    tick(3);
    entry_car_present = 0;
    entry_car_passed = 0;
    tick(4);
    // randomized concurrent traffic
    fork
      repeat (30) entry_txn();
      repeat (30) exit_txn();
    join
    tick(10);
    chk("random_entry_queue_empty", q_en.size(), 0);
    chk("random_exit_queue_empty", q_ex.size(), 0);
    chk("random_denied_count", int'(denied_count), exp_denied);
    // saturate the denial counter
    is_vacated_space = 0;
    uni_is_vacated_space = 0;
    repeat (262) begin
      entry_car_present = 1;
      n = 0;
      while (!entry_denied && n < 20) begin
        tick();
        n++;
      end
      exp_denied = sat_inc(exp_denied);
      entry_car_present = 0;
      n = 0;
      while (entry_denied && n < 40) begin
        tick();
        n++;
      end
      tick();
    end
    chk("denied_count_saturates", int'(denied_count), exp_denied);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
